// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: req/gnt/rvalid data bus between the load/store unit and memory
interface riscv_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-transaction load/store unit that stalls the core until its bus access completes
module riscv_lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              data_req_i,
   input  logic              data_wr_i,
   input  logic [1:0]        data_byte_i,
   input  logic              zero_extnd_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] ld_data_o,
   output logic              misaligned_o,
   riscv_lsu_if.master       mem
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
   state_t state, state_n;
   logic              mis;
   logic [3:0]        be;
   logic [DATA_W-1:0] wd, sh, ld;
   logic [1:0]        sz_q, lo_q;
   logic              zx_q;
   assign mis = (data_byte_i == 2'b11) | (data_byte_i == 2'b01 & data_addr_i[0]) |
                (data_byte_i == 2'b10 & |data_addr_i[1:0]);
   assign be  = data_byte_i == 2'b00 ? 4'b0001 << data_addr_i[1:0] :
                data_byte_i == 2'b01 ? 4'b0011 << data_addr_i[1:0] : 4'b1111;
   assign wd  = data_byte_i == 2'b00 ? {4{data_wdata_i[7:0]}} :
                data_byte_i == 2'b01 ? {2{data_wdata_i[15:0]}} : data_wdata_i;
   // extraction uses the attributes latched at launch, not the live inputs
   assign sh  = mem.rdata >> {lo_q, 3'b000};
   assign ld  = sz_q == 2'b00 ? {{24{~zx_q & sh[7]}}, sh[7:0]} :
                sz_q == 2'b01 ? {{16{~zx_q & sh[15]}}, sh[15:0]} : sh;
   assign stall_o = data_req_i & (state != DONE) & ~reset;
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_n;
   always_comb begin
      state_n = state;
      state_n = state == IDLE     ? (data_req_i ? (mis ? DONE : REQ) : IDLE) :
                state == REQ      ? (mem.gnt ? (mem.we ? DONE : WAIT_RSP) : REQ) :
                state == WAIT_RSP ? (mem.rvalid ? DONE : WAIT_RSP) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_data_o    <= '0;
         misaligned_o <= 1'b0;
         mem.req      <= 1'b0;
         mem.we       <= 1'b0;
         mem.addr     <= '0;
         mem.be       <= '0;
         mem.wdata    <= '0;
         sz_q         <= '0;
         lo_q         <= '0;
         zx_q         <= 1'b0;
      end else begin
         misaligned_o <= state == IDLE & data_req_i & mis;
         if (state == IDLE & data_req_i & mis)
            ld_data_o <= '0;
         if (state == IDLE & data_req_i & ~mis) begin
            mem.req   <= 1'b1;
            mem.we    <= data_wr_i;
            mem.addr  <= {data_addr_i[ADDR_W-1:2], 2'b00};
            mem.be    <= be;
            mem.wdata <= wd;
            sz_q      <= data_byte_i;
            lo_q      <= data_addr_i[1:0];
            zx_q      <= zero_extnd_i;
         end
         if (state == REQ & mem.gnt)
            mem.req <= 1'b0;
         if (state == WAIT_RSP & mem.rvalid)
            ld_data_o <= ld;
      end
   end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed transactions with a load-result scoreboard checked by immediate assertions
module tb_riscv_lsu;
   logic        clk = 0, reset = 1;
   logic        data_req = 0, data_wr = 0, zero_extnd = 0;
   logic [1:0]  data_byte = 0;
   logic [31:0] data_addr = 0, data_wdata = 0;
   logic        stall, misaligned;
   logic [31:0] ld_data;
   int          errors = 0, checks = 0;
   logic [31:0] sb[$];
   logic [31:0] last_ld = 0;

   riscv_lsu_if bus();

   riscv_lsu dut (
      .clk(clk), .reset(reset), .data_req_i(data_req), .data_wr_i(data_wr),
      .data_byte_i(data_byte), .zero_extnd_i(zero_extnd), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .stall_o(stall), .ld_data_o(ld_data),
      .misaligned_o(misaligned), .mem(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // n=0 is the IDLE cycle; REQ lasts gd+1 cycles; rvalid comes rd cycles after gnt
   task automatic access(input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] a, input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] rdat, input logic [31:0] exp_a, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input int exp_stall, input logic [31:0] exp_ld);
      int n = 0, st = 0;
      bit done = 0;
      if (!wr) sb.push_back(exp_ld);
      while (!done && n < 40) begin
         data_req   = 1;
         data_wr    = wr;
         data_byte  = n == 0 ? sz : ~sz;
         zero_extnd = n == 0 ? zx : ~zx;
         data_addr  = n == 0 ? a : a ^ 32'h0000_0F0D;
         data_wdata = n == 0 ? wd : ~wd;
         bus.gnt    = n == gd + 1;
         bus.rvalid = !wr && n == gd + 1 + rd;
         bus.rdata  = bus.rvalid ? rdat : 32'h5A5A_A5A5;
         #1;
         if (n == 0) chk("idle_req", bus.req, 0);
         if (n >= 1 && n <= gd + 1) begin
            chk("req", bus.req, 1);
            chk("addr", bus.addr, exp_a);
            chk("be", {28'd0, bus.be}, {28'd0, exp_be});
            chk("we", bus.we, wr);
            if (wr) chk("wdata", bus.wdata, exp_wd);
         end
         if (stall) st++;
         else done = 1;
         if (!done) begin
            @(negedge clk);
            n++;
         end
      end
      bus.gnt = 0;
      bus.rvalid = 0;
      chk("done_reached", done, 1);
      chk("stall_cycles", st, exp_stall);
      chk("done_req", bus.req, 0);
      chk("done_mis", misaligned, 0);
      if (!wr && sb.size() > 0) last_ld = sb.pop_front();
      chk(wr ? "st_ld_kept" : "ld_data", ld_data, last_ld);
   endtask

   task automatic misal(input logic [1:0] sz, input logic [31:0] a);
      data_req = 1; data_wr = 0; data_byte = sz; data_addr = a;
      #1;
      chk("mis_stall0", stall, 1);
      chk("mis_req0", bus.req, 0);
      @(negedge clk); #1;
      chk("mis_pulse", misaligned, 1);
      chk("mis_stall1", stall, 0);
      chk("mis_req1", bus.req, 0);
      last_ld = 0;
      chk("mis_ld", ld_data, last_ld);
      @(negedge clk);
      data_req = 0;
      #1;
      chk("mis_clear", misaligned, 0);
      chk("mis_req2", bus.req, 0);
   endtask

   task automatic idle();
      @(negedge clk);
      data_req = 0;
      #1;
      chk("idle_stall", stall, 0);
   endtask

   initial begin
      bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
      data_req = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_req", bus.req, 0);
      chk("rst_ld", ld_data, 0);
      chk("rst_mis", misaligned, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_be", {28'd0, bus.be}, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_we", bus.we, 0);
      data_req = 0;
      reset = 0;
      @(negedge clk);
      access(0, 2'b10, 0, 32'h100, 0, 0, 2, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 4, 32'hDEADBEEF);
      idle();
      @(negedge clk);
      access(0, 2'b00, 0, 32'h203, 0, 0, 1, 32'h80FF_0000, 32'h200, 4'b1000, 0, 3, 32'hFFFF_FF80);
      idle();
      @(negedge clk);
      access(0, 2'b00, 1, 32'h203, 0, 0, 1, 32'h80FF_0000, 32'h200, 4'b1000, 0, 3, 32'h0000_0080);
      idle();
      @(negedge clk);
      access(1, 2'b01, 0, 32'h12, 32'h0000_ABCD, 3, 0, 0, 32'h10, 4'b1100, 32'hABCD_ABCD, 5, 0);
      idle();
      @(negedge clk);
      misal(2'b10, 32'h102);
      misal(2'b01, 32'h101);
      misal(2'b11, 32'h200);
      @(negedge clk);
      access(1, 2'b00, 0, 32'h0, 32'h1234_5678, 0, 0, 0, 32'h0, 4'b0001, 32'h7878_7878, 2, 0);
      @(negedge clk);
      access(0, 2'b01, 1, 32'h6, 0, 1, 3, 32'h8001_0000, 32'h4, 4'b1100, 0, 6, 32'h0000_8001);
      idle();
      @(negedge clk);
      data_req = 1; data_wr = 0; data_byte = 2'b10; data_addr = 32'h40;
      @(negedge clk);
      bus.gnt = 1;
      #1;
      chk("rst_t_req", bus.req, 1);
      @(negedge clk);
      bus.gnt = 0;
      reset = 1;
      #1;
      chk("rst_t_stall", stall, 0);
      @(negedge clk);
      reset = 0; data_req = 0;
      bus.rvalid = 1; bus.rdata = 32'h1234_5678;
      #1;
      chk("rst_t_req0", bus.req, 0);
      chk("rst_t_ld0", ld_data, 0);
      chk("rst_t_stall0", stall, 0);
      @(negedge clk);
      bus.rvalid = 0;
      #1;
      chk("rst_t_late_rv", ld_data, 0);
      chk("rst_t_mis", misaligned, 0);
      data_req = 1;
      #1;
      chk("rst_t_follow1", stall, 1);
      data_req = 0;
      #1;
      chk("rst_t_follow0", stall, 0);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of riscv_control. Consumes data_req/data_wr/data_byte/zero_extnd plus the ALU-computed address and rs2 store data.
- Runs one memory transaction on a req/gnt/rvalid data bus, stalling the single-cycle core until it completes.
- Performs byte-lane alignment for stores and extract/sign-or-zero extension for loads. Returns load data for rf_wr_data = MEM write-back.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; 4 byte lanes)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- data_req_i  in  1  memory instruction in the current cycle
- data_wr_i  in  1  1 = store, 0 = load
- data_byte_i  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved
- zero_extnd_i  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- data_addr_i  in  ADDR_W  byte address from the ALU
- data_wdata_i  in  DATA_W  store data (rs2), in the low bytes
- stall_o  out  1  hold PC and regfile write while high
- ld_data_o  out  DATA_W  extended load result
- misaligned_o  out  1  one-cycle pulse on a misaligned or reserved access
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_addr_o  out  ADDR_W  word-aligned address, {data_addr[ADDR_W-1:2], 2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_W  lane-replicated store data
- mem_gnt_i  in  1  bus accepts request this cycle
- mem_rvalid_i  in  1  read data valid; always at least 1 cycle after gnt
- mem_rdata_i  in  DATA_W  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP, DONE. Reset -> IDLE.
- Registered outputs reset to 0: ld_data_o, misaligned_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o.
- stall_o (combinational) = data_req_i & (state != DONE). It is 0 during reset.
- IDLE:
  - If data_req_i is high and the access is misaligned, go to DONE. Set misaligned_o = 1 for that DONE cycle. No bus request is issued. ld_data_o is set to 0.
  - If data_req_i is high and aligned, latch the attributes, drive the mem_* outputs, and go to REQ.
- Misalignment rules: halfword with addr[0] = 1; word with addr[1:0] != 0; data_byte = 11 at any address.
- REQ:
  - mem_req_o = 1. mem_addr/we/be/wdata stay stable until mem_gnt_i.
  - On gnt with a store: drop mem_req_o next cycle and go to DONE.
  - On gnt with a load: drop mem_req_o and go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rvalid_i, register the extracted and extended load data into ld_data_o, then go to DONE.
  - mem_rvalid_i in any other state is ignored.
- DONE:
  - Exactly one cycle. stall_o = 0, so the core retires the instruction and writes ld_data_o.
  - Always returns to IDLE. A back-to-back memory instruction starts from IDLE on the next cycle (1 bubble).
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
- Load data:
  - Shift: sh = mem_rdata >> (8*addr[1:0]).
  - byte: extend sh[7:0]; halfword: extend sh[15:0]; word: sh.
  - Extension is sign or zero per the latched zero_extnd_i.
- Minimum latency:
  - Store with gnt in the first REQ cycle: 2 stall cycles (IDLE, REQ), then DONE.
  - Load: 3 + rvalid delay.
- ld_data_o holds its value until the next load completes. Stores leave it unchanged.
- Reset in any state (including REQ with gnt, or WAIT_RSP) returns to IDLE with mem_req_o = 0 on the next cycle. A late rvalid arriving after reset is dropped.
- Input changes while in REQ or WAIT_RSP have no effect; latched attributes are used.

Test Plan:
- LW, addr 0x100, gnt in the first REQ cycle, rvalid 2 cycles later, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, stall_o high for 4 cycles, ld_data_o = 0xDEADBEEF in DONE.
- LB, addr 0x203, rdata 0x80FF_0000 -> be 1000, ld_data_o = 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH, addr 0x12, wdata 0x0000ABCD, gnt delayed 3 cycles -> req/addr 0x10/be 1100/wdata 0xABCDABCD stable throughout; DONE 1 cycle after gnt; ld_data_o unchanged.
- LW at 0x102, then LH at 0x101 -> each gives a 1-cycle misaligned_o pulse, no mem_req_o, ld_data_o = 0, stall_o low by the 2nd cycle.
- Back-to-back SB 0x0 then LHU 0x6 (rdata 0x8001_0000) -> IDLE bubble between the two, LHU be 1100, ld_data_o = 0x00008001.
- Assert reset during WAIT_RSP, then pulse rvalid -> state IDLE, mem_req_o = 0, ld_data_o = 0, stall_o follows data_req_i once reset is released.
